// File: rtl/ahb2apb_arb_pkg.sv
// Shared types and constants for the AHB2APB requester arbiter.
package ahb2apb_arb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } arb_state_e;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahb2apb_arbiter_rr.sv
// Combinational round-robin select: searches from last+1 with wrap and
// returns the winner as one-hot grant plus binary index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk offsets from farthest to nearest so the nearest active requester wins.
  always_comb begin
    int j;
    any = 1'b0;
    idx = last;
    for (int k = N; k >= 1; k--) begin
      j = int'(last) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        any = 1'b1;
        idx = IDX_W'(j);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_gnt
    assign gnt[gi] = any && (idx == IDX_W'(gi));
  end

endmodule

// File: rtl/ahb2apb_arbiter.sv
// Round-robin arbiter driving single non-pipelined AHB-lite transfers to the bridge.
// Optional hready-low abort enabled by defining AHB2APB_ARB_TIMEOUT_EN.
module ahb2apb_arbiter
  import ahb2apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       hclk,
  input  logic                       hreset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       hsel,
  output logic [1:0]                 htrans,
  output logic [ADDR_W-1:0]          haddr,
  output logic                       hwrite,
  output logic [2:0]                 hsize,
  output logic [DATA_W-1:0]          hwdata,
  input  logic                       hready,
  input  logic                       hresp,
  input  logic [DATA_W-1:0]          hrdata,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       tmo_flag
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W != 32 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("ahb2apb_arbiter: unsupported parameter set");
  end

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                hsel_q, hsel_d;
  htrans_e             htrans_q, htrans_d;
  logic [ADDR_W-1:0]   haddr_q, haddr_d;
  logic                hwrite_q, hwrite_d;
  logic [DATA_W-1:0]   hwdata_q, hwdata_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  rr_gnt;
  logic [IDX_W-1:0]    rr_idx;
  logic                rr_any;

`ifdef AHB2APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                tmo_flag_q, tmo_flag_d;
`endif

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req  (req_valid),
    .last (owner_q),
    .gnt  (rr_gnt),
    .idx  (rr_idx),
    .any  (rr_any)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wdata_d     = wdata_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    hsel_d      = hsel_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    busy_d      = busy_q;
`ifdef AHB2APB_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_flag_d  = tmo_flag_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rr_any) begin
          req_ready_d = rr_gnt;
          owner_d     = rr_idx;
          haddr_d     = req_addr[int'(rr_idx)*ADDR_W +: ADDR_W];
          hwrite_d    = req_write[rr_idx];
          wdata_d     = req_wdata[int'(rr_idx)*DATA_W +: DATA_W];
          busy_d      = 1'b1;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // First ADDR cycle carries the grant pulse; the address phase starts next.
        if (!hsel_q) begin
          hsel_d   = 1'b1;
          htrans_d = HT_NONSEQ;
        end else if (hready) begin
          hsel_d   = 1'b0;
          htrans_d = HT_IDLE;
          hwdata_d = wdata_q;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (hready) begin
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_rdata_d = hwrite_q ? '0 : hrdata;
          rsp_err_d   = hresp;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef AHB2APB_ARB_TIMEOUT_EN
    // Only cycles where the bridge actually owes us hready are counted.
    if ((state_q == ST_DATA || (state_q == ST_ADDR && hsel_q)) && !hready) begin
      if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        hsel_d      = 1'b0;
        htrans_d    = HT_IDLE;
        rsp_valid_d = NUM_REQ'(1) << owner_q;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
        tmo_flag_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
        tmo_cnt_d   = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end else begin
      tmo_cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      owner_q     <= LAST_IDX;
      wdata_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      hsel_q      <= 1'b0;
      htrans_q    <= HT_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      busy_q      <= 1'b0;
`ifdef AHB2APB_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      tmo_flag_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      hsel_q      <= hsel_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      busy_q      <= busy_d;
`ifdef AHB2APB_ARB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_flag_q  <= tmo_flag_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign hsel      = hsel_q;
  assign htrans    = htrans_q;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hsize     = HSIZE_WORD;
  assign hwdata    = hwdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
`ifdef AHB2APB_ARB_TIMEOUT_EN
  assign tmo_flag  = tmo_flag_q;
`else
  assign tmo_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_ahb2apb_arbiter.sv
// Directed bench for ahb2apb_arbiter: writes, waited reads, round-robin order,
// ERROR response, reset mid-transfer and hready stall / timeout abort.
module tb_ahb2apb_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                 hclk = 1'b0;
  logic                 hreset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_write = '0;
  logic [NUM_REQ*AW-1:0] req_addr = '0;
  logic [NUM_REQ*DW-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]   req_ready, rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err, hsel, hwrite, busy, tmo_flag;
  logic [1:0]           htrans;
  logic [AW-1:0]        haddr;
  logic [2:0]           hsize;
  logic [DW-1:0]        hwdata;
  logic                 hready = 1'b1;
  logic                 hresp = 1'b0;
  logic [DW-1:0]        hrdata = '0;
  logic [1:0]           owner;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int overlap = 0;

  ahb2apb_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)
  ) dut (
    .hclk(hclk), .hreset(hreset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hsel(hsel), .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .busy(busy), .owner(owner), .tmo_flag(tmo_flag)
  );

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;
  always @(negedge hclk) if (!hreset && (|(req_ready & rsp_valid))) overlap <= overlap + 1;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic post(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[r] = 1'b1;
    req_write[r] = wr;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    tick(); tick();
    checks++; if (htrans !== 2'b00 || hsel !== 1'b0) begin errors++; $display("FAIL reset_bus: htrans=%b hsel=%b want 00/0", htrans, hsel); end
    checks++; if (hsize !== 3'b010) begin errors++; $display("FAIL reset_hsize: got %b want 010", hsize); end
    checks++; if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_hs: rdy=%b rsp=%b busy=%b want 0", req_ready, rsp_valid, busy); end
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL reset_owner: got %0d want 3", owner); end
    checks++; if (haddr !== 32'h0 || hwdata !== 32'h0 || hwrite !== 1'b0 || tmo_flag !== 1'b0) begin errors++; $display("FAIL reset_data: haddr=%h hwdata=%h hwrite=%b tmo=%b want 0", haddr, hwdata, hwrite, tmo_flag); end
    hreset = 1'b0;
    tick();
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_write();
    post(0, 1'b1, 32'h0000_0010, 32'hA5A5_5A5A);
    tick();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wr_grant: got %b want 0001", req_ready); end
    req_valid = '0;
    tick();
    checks++; if (htrans !== 2'b10 || hsel !== 1'b1 || hwrite !== 1'b1 || haddr !== 32'h10) begin errors++; $display("FAIL wr_addr: htrans=%b hsel=%b hwrite=%b haddr=%h want 10/1/1/00000010", htrans, hsel, hwrite, haddr); end
    tick();
    checks++; if (hwdata !== 32'hA5A5_5A5A || htrans !== 2'b00 || hsel !== 1'b0) begin errors++; $display("FAIL wr_data: hwdata=%h htrans=%b hsel=%b want a5a55a5a/00/0", hwdata, htrans, hsel); end
    tick();
    checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL wr_rsp: rsp=%b err=%b rdy=%b want 0001/0/0000", rsp_valid, rsp_err, req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy: got %b want 0", busy); end
    $display("req0 write 00000010 completed at cycle %0d", cyc);
  endtask

  task automatic test_read_wait();
    post(2, 1'b0, 32'h0000_0020, 32'h0);
    tick();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rd_grant: got %b want 0100", req_ready); end
    req_valid = '0;
    tick();
    checks++; if (htrans !== 2'b10 || hwrite !== 1'b0 || haddr !== 32'h20) begin errors++; $display("FAIL rd_addr: htrans=%b hwrite=%b haddr=%h want 10/0/00000020", htrans, hwrite, haddr); end
    tick();
    hready = 1'b0;
    tick();
    tick();
    checks++; if (rsp_valid !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL rd_wait: rsp=%b busy=%b want 0000/1", rsp_valid, busy); end
    hready = 1'b1;
    hrdata = 32'h1234_5678;
    tick();
    checks++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp: rsp=%b rdata=%h err=%b want 0100/12345678/0", rsp_valid, rsp_rdata, rsp_err); end
    hrdata = '0;
    $display("req2 read 00000020 -> %h at cycle %0d", rsp_rdata, cyc);
  endtask

  task automatic test_round_robin();
    int last_cyc;
    int gap_bad;
    int onehot_bad;
    last_cyc = 0;
    gap_bad = 0;
    onehot_bad = 0;
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) post(r, 1'b1, 32'h100 + 32'(r*4), 32'(r));
    for (int i = 0; i < 8; i++) begin
      tick();
      for (int t = 0; t < 10 && req_ready == 4'b0; t++) tick();
      checks++; if (req_ready !== (4'b0001 << (i % 4))) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", i, req_ready, 4'b0001 << (i % 4)); end
      if (i > 0 && cyc - last_cyc < 3) gap_bad++;
      if (!$onehot(req_ready)) onehot_bad++;
      last_cyc = cyc;
      $display("rr grant %0d -> req_ready=%b at cycle %0d", i, req_ready, cyc);
    end
    req_valid = '0;
    tick(); tick(); tick(); tick();
    checks++; if (gap_bad !== 0) begin errors++; $display("FAIL rr_spacing: %0d grants closer than 3 cycles, want 0", gap_bad); end
    checks++; if (onehot_bad !== 0) begin errors++; $display("FAIL rr_onehot: %0d non-one-hot grants, want 0", onehot_bad); end
  endtask

  task automatic test_error();
    post(1, 1'b0, 32'h0000_0044, 32'h0);
    tick();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL err_grant: got %b want 0010", req_ready); end
    req_valid = '0;
    tick();
    tick();
    hready = 1'b0;
    hresp = 1'b1;
    tick();
    hready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_rsp: rsp=%b err=%b busy=%b want 0010/1/0", rsp_valid, rsp_err, busy); end
    hresp = 1'b0;
    tick();
    checks++; if (rsp_valid !== 4'b0 || rsp_err !== 1'b1 || htrans !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL err_idle: rsp=%b err=%b htrans=%b busy=%b want 0000/1/00/0", rsp_valid, rsp_err, htrans, busy); end
    $display("req1 read 00000044 error response at cycle %0d", cyc);
  endtask

  task automatic test_reset_mid();
    int spurious;
    spurious = 0;
    post(3, 1'b1, 32'h0000_0030, 32'hCAFE_F00D);
    tick();
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rst_grant: got %b want 1000", req_ready); end
    req_valid = '0;
    tick();
    tick();
    hready = 1'b0;
    checks++; if (hwdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_hwdata: got %h want cafef00d", hwdata); end
    #2 hreset = 1'b1;
    #1;
    checks++; if (htrans !== 2'b00 || hsel !== 1'b0 || haddr !== 32'h0 || hwdata !== 32'h0 || hwrite !== 1'b0) begin errors++; $display("FAIL rst_async_bus: htrans=%b hsel=%b haddr=%h hwdata=%h hwrite=%b want 0", htrans, hsel, haddr, hwdata, hwrite); end
    checks++; if (busy !== 1'b0 || owner !== 2'd3 || rsp_valid !== 4'b0) begin errors++; $display("FAIL rst_async_ctl: busy=%b owner=%0d rsp=%b want 0/3/0000", busy, owner, rsp_valid); end
    hready = 1'b1;
    tick(); tick();
    hreset = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (rsp_valid !== 4'b0) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL rst_no_rsp: %0d rsp_valid cycles, want 0", spurious); end
    post(0, 1'b1, 32'h50, 32'h1);
    post(3, 1'b1, 32'h54, 32'h2);
    tick();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b want 0001", req_ready); end
    req_valid = '0;
    tick(); tick(); tick();
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rst_after_rsp: got %b want 0001", rsp_valid); end
    $display("reset mid-transfer dropped req3, req0 served at cycle %0d", cyc);
  endtask

`ifdef AHB2APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    lat = 0;
    post(2, 1'b0, 32'h0000_0060, 32'h0);
    hrdata = 32'hDEAD_BEEF;
    tick();
    req_valid = '0;
    hready = 1'b0;
    while (rsp_valid == 4'b0 && lat < 40) begin
      tick();
      lat++;
    end
    checks++; if (lat !== 17) begin errors++; $display("FAIL tmo_latency: got %0d want 17 cycles after grant", lat); end
    checks++; if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rsp: rsp=%b err=%b rdata=%h want 0100/1/00000000", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (tmo_flag !== 1'b1 || htrans !== 2'b00 || hsel !== 1'b0) begin errors++; $display("FAIL tmo_abort: tmo=%b htrans=%b hsel=%b want 1/00/0", tmo_flag, htrans, hsel); end
    hready = 1'b1;
    hrdata = '0;
    post(1, 1'b1, 32'h64, 32'h3);
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    checks++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || tmo_flag !== 1'b1) begin errors++; $display("FAIL tmo_sticky: rsp=%b err=%b tmo=%b want 0010/0/1", rsp_valid, rsp_err, tmo_flag); end
    $display("req2 read 00000060 timed out after %0d cycles", lat);
  endtask
`else
  task automatic test_stall();
    int bad;
    bad = 0;
    post(2, 1'b0, 32'h0000_0060, 32'h0);
    tick();
    req_valid = '0;
    hready = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (htrans !== 2'b10 || rsp_valid !== 4'b0) bad++;
    end
    checks++; if (bad !== 0 || tmo_flag !== 1'b0) begin errors++; $display("FAIL stall_hold: bad=%0d tmo=%b want 0/0", bad, tmo_flag); end
    hready = 1'b1;
    hrdata = 32'h0BAD_F00D;
    tick(); tick();
    checks++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 32'h0BAD_F00D || rsp_err !== 1'b0) begin errors++; $display("FAIL stall_rsp: rsp=%b rdata=%h err=%b want 0100/0badf00d/0", rsp_valid, rsp_rdata, rsp_err); end
    hrdata = '0;
    $display("req2 read 00000060 after 20-cycle stall -> %h", rsp_rdata);
  endtask
`endif

  task automatic test_no_overlap();
    tick();
    checks++; if (overlap !== 0) begin errors++; $display("FAIL no_overlap: %0d cycles with req_ready and rsp_valid, want 0", overlap); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_round_robin();
    test_error();
    test_reset_mid();
`ifdef AHB2APB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    test_no_overlap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
